// File: rtl/teclado_debounce_pkg.sv
// Shared keypad definitions: key count, debounce FSM state encoding and vector helpers.
package teclado_debounce_pkg;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } teclado_state_t;

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  function automatic logic has_multi(input logic [NUM_KEYS-1:0] v);
    return (v & (v - NUM_KEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/teclado_sync.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module teclado_sync #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  logic [DATA_W-1:0] meta_q, meta_d;
  logic [DATA_W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/teclado_debounce.sv
// Keypad front end: synchronize, debounce single-key presses, emit one-hot key and strobe.
// Optional auto-repeat of key_strobe while a key is held: define TECLADO_REPEAT_EN.
module teclado_debounce
  import teclado_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                key_strobe,
  output logic                key_held,
  output logic                multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("teclado_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [NUM_KEYS-1:0] sync;

  teclado_sync #(
    .DATA_W(NUM_KEYS)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (raw_keys),
    .d_out(sync)
  );

  teclado_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic                strobe_q, strobe_d;
  logic                multi_q, multi_d;
  logic                accept;
  logic                rep_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_one_hot(sync)) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (sync != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          key_d   = cand_q;
          accept  = 1'b1;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sync != cand_q) begin
          cnt_d   = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (sync == cand_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          key_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    strobe_d = accept | rep_fire;
    multi_d  = has_multi(sync);
  end

`ifdef TECLADO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic [REP_W-1:0] rep_last;

  // Counter idles at zero outside a steady PRESSED, so every entry restarts the initial delay.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_fire    = 1'b0;
    rep_last    = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
    if (state_q == PRESSED && sync == cand_q) begin
      rep_first_d = rep_first_q;
      if (rep_cnt_q == rep_last) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
      multi_q  <= multi_d;
    end
  end

  // Output register stage: every port is a flop, one cycle behind the FSM decision.
  logic [NUM_KEYS-1:0] key_out_q, key_out_d;
  logic                key_strobe_q, key_strobe_d;
  logic                key_held_q, key_held_d;
  logic                multi_key_q, multi_key_d;

  always_comb begin
    key_out_d    = key_q;
    key_strobe_d = strobe_q;
    key_held_d   = (state_q == PRESSED) || (state_q == REL_DB);
    multi_key_d  = multi_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_out_q    <= '0;
      key_strobe_q <= 1'b0;
      key_held_q   <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      key_out_q    <= key_out_d;
      key_strobe_q <= key_strobe_d;
      key_held_q   <= key_held_d;
      multi_key_q  <= multi_key_d;
    end
  end

  assign key_out    = key_out_q;
  assign key_strobe = key_strobe_q;
  assign key_held   = key_held_q;
  assign multi_key  = multi_key_q;

endmodule

// File: tb/tb_teclado_debounce.sv
// Bench for teclado_debounce: directed scenarios plus random key activity against a run-length model.
module tb_teclado_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] raw_keys;
  logic [9:0] key_out;
  logic       key_strobe;
  logic       key_held;
  logic       multi_key;

  always #5 clk = ~clk;

  teclado_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_keys  (raw_keys),
    .key_out   (key_out),
    .key_strobe(key_strobe),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw is seen two edges late; a press needs D+1 equal one-hot samples
  // gathered while nothing is accepted, a release needs D+1 consecutive differing samples.
  logic [9:0] m_s1, m_sync, m_cand, m_acc;
  int         m_run, m_rel, m_anchor, n;
  logic       m_stb, m_multi;
  logic [9:0] o_key;
  logic       o_stb, o_held, o_multi;

  initial begin
    m_s1 = '0; m_sync = '0; m_cand = '0; m_acc = '0;
    m_run = 0; m_rel = 0; m_anchor = 0; n = 0;
    m_stb = 0; m_multi = 0;
    o_key = '0; o_stb = 0; o_held = 0; o_multi = 0;
  end

  always @(posedge clk) begin
    logic [9:0] s;
    logic       stb;
    int         dd;
    n++;
    if (rst) begin
      m_s1 = '0; m_sync = '0; m_cand = '0; m_acc = '0;
      m_run = 0; m_rel = 0; m_stb = 0; m_multi = 0;
      o_key = '0; o_stb = 0; o_held = 0; o_multi = 0;
    end else begin
      o_key   = m_acc;
      o_held  = (m_acc != '0);
      o_stb   = m_stb;
      o_multi = m_multi;
      s       = m_sync;
      m_multi = ($countones(s) >= 2);
      stb     = 1'b0;
      if (m_acc == '0) begin
        if (m_run == 0) begin
          if ($countones(s) == 1) begin
            m_cand = s;
            m_run  = 1;
          end
        end else if (s != m_cand) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == D + 1) begin
            m_acc    = m_cand;
            m_run    = 0;
            m_rel    = 0;
            m_anchor = n;
            stb      = 1'b1;
          end
        end
      end else begin
        if (s == m_acc) begin
          if (m_rel > 0) begin
            m_rel    = 0;
            m_anchor = n;
          end else begin
            dd = n - m_anchor;
`ifdef TECLADO_REPEAT_EN
            if (dd >= RD && ((dd - RD) % RP) == 0) stb = 1'b1;
`else
            if (dd < 0) stb = 1'b1;
`endif
          end
        end else begin
          m_rel++;
          if (m_rel == D + 1) begin
            m_acc = '0;
            m_rel = 0;
            m_run = 0;
          end
        end
      end
      m_stb  = stb;
      m_sync = m_s1;
      m_s1   = raw_keys;
    end
  end

  task automatic check_outputs();
    checks++;
    assert (key_out === o_key) else begin
      errors++;
      $error("FAIL key_out cyc=%0d observed=%h expected=%h", n, key_out, o_key);
    end
    checks++;
    assert (key_strobe === o_stb) else begin
      errors++;
      $error("FAIL key_strobe cyc=%0d observed=%b expected=%b", n, key_strobe, o_stb);
    end
    checks++;
    assert (key_held === o_held) else begin
      errors++;
      $error("FAIL key_held cyc=%0d observed=%b expected=%b", n, key_held, o_held);
    end
    checks++;
    assert (multi_key === o_multi) else begin
      errors++;
      $error("FAIL multi_key cyc=%0d observed=%b expected=%b", n, multi_key, o_multi);
    end
  endtask

  task automatic cyc(input logic [9:0] r, input logic rs);
    raw_keys = r;
    rst      = rs;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input logic [9:0] r, input int k);
    repeat (k) cyc(r, 1'b0);
  endtask

  task automatic hold_track(input logic [9:0] r, input int k, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 0; i < k; i++) begin
      cyc(r, 1'b0);
      if (key_strobe === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  initial begin
    int         first, cnt, exp_cnt, len, sel;
    logic [9:0] pat;
    raw_keys = '0;
    rst      = 1'b1;
    @(negedge clk);
    cyc('0, 1'b1);
    cyc('0, 1'b1);

    // Clean press and release
    hold_track(10'h004, 20, first, cnt);
    checks++;
    assert (first === 7) else begin
      errors++;
      $error("FAIL clean_press_latency observed=%0d expected=7", first);
    end
    checks++;
    assert (key_out === 10'h004) else begin
      errors++;
      $error("FAIL clean_press_key observed=%h expected=004", key_out);
    end
    hold(10'h000, 12);

    // Bounce on press
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 10'h001 : 10'h000, 2);
    hold(10'h001, 12);
    hold(10'h000, 12);

    // Two keys, then one
    hold(10'h003, 10);
    hold(10'h002, 15);
    hold(10'h000, 12);

    // Bounce on release
    hold(10'h200, 12);
    hold(10'h000, 2);
    hold(10'h200, 10);
    hold(10'h000, 12);

    // Direct swap between keys
    hold(10'h020, 12);
    hold(10'h040, 15);
    hold(10'h000, 12);

    // Reset during press debounce
    hold(10'h010, 4);
    cyc(10'h010, 1'b1);
    checks++;
    assert ({key_out, key_strobe, key_held, multi_key} === 13'd0) else begin
      errors++;
      $error("FAIL reset_mid_press observed=%h expected=0", {key_out, key_strobe, key_held, multi_key});
    end
    hold(10'h010, 15);
    hold(10'h000, 12);

    // Long hold: repeat behaviour
    hold_track(10'h008, 40, first, cnt);
`ifdef TECLADO_REPEAT_EN
    exp_cnt = 6;
`else
    exp_cnt = 1;
`endif
    checks++;
    assert (cnt === exp_cnt) else begin
      errors++;
      $error("FAIL long_hold_strobes observed=%0d expected=%0d", cnt, exp_cnt);
    end
    hold(10'h000, 12);

    // Random key activity
    pat = '0;
    for (int seg = 0; seg < 300; seg++) begin
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 14);
      if (sel < 40)       pat = 10'(1) << $urandom_range(0, 9);
      else if (sel < 60)  pat = '0;
      else if (sel < 80)  pat = 10'($urandom_range(0, 1023)) | (10'(1) << $urandom_range(0, 9));
      if (sel == 99) cyc(pat, 1'b1);
      else           hold(pat, len);
    end
    hold(10'h000, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
